// File: rtl/exec_step_ctrl_pkg.sv
// Shared step-controller types: FSM states and command codes.
// Also used by the debug/UART front end that issues commands.
package exec_step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_PAUSE = 2'b11
  } cmd_t;

  function automatic logic is_enabled(state_t s);
    return (s == S_RUN) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/exec_step_ctrl_sat_counter.sv
// Saturating up-counter with clear and load-one.
// Clear wins over load-one, which wins over increment.
module sat_counter #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load1,
  input  logic              inc,
  output logic [N_BITS-1:0] count
);

  localparam logic [N_BITS-1:0] MAX = '1;

  // count register, holds at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= N_BITS'(1);
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/exec_step_ctrl.sv
// Run/step/halt controller gating the whole pipeline.
// Counts enabled cycles; halt in WB overrides any command.
module exec_step_ctrl
  import exec_step_ctrl_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int N_CMD  = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [N_CMD-1:0]  i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt_wb,
  output logic              o_enable,
  output logic              o_running,
  output logic              o_halted,
  output logic              o_step_done,
  output logic [N_BITS-1:0] o_cycle_count
);

  state_t state;
  state_t state_n;
  logic   accept;
  logic   c_clear;
  logic   c_run;
  logic   c_step;
  logic   c_pause;
  logic   cnt_clear;
  logic   cnt_load1;

  assign o_cmd_ready = (state != S_STEP);
  assign o_enable    = is_enabled(state);
  assign accept      = i_cmd_valid && o_cmd_ready;

  // command decode, only meaningful when accepted
  always_comb begin
    c_clear = 1'b0;
    c_run   = 1'b0;
    c_step  = 1'b0;
    c_pause = 1'b0;
    if (accept) begin
      unique case (1'b1)
        (i_cmd == N_CMD'(CMD_CLEAR)): c_clear = 1'b1;
        (i_cmd == N_CMD'(CMD_RUN)):   c_run   = 1'b1;
        (i_cmd == N_CMD'(CMD_STEP)):  c_step  = 1'b1;
        (i_cmd == N_CMD'(CMD_PAUSE)): c_pause = 1'b1;
        default: ;
      endcase
    end
  end

  // next state and counter control
  always_comb begin
    state_n   = state;
    cnt_clear = 1'b0;
    cnt_load1 = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (c_run) begin
          state_n = S_RUN;
        end else if (c_step) begin
          state_n = S_STEP;
        end else if (c_clear) begin
          cnt_clear = 1'b1;
        end
      end
      S_RUN: begin
        if (i_halt_wb) begin
          state_n = S_HALTED;
        end else if (c_pause) begin
          state_n = S_IDLE;
        end else if (c_clear) begin
          cnt_load1 = 1'b1;
        end
      end
      S_STEP: begin
        state_n = i_halt_wb ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (c_clear) begin
          state_n   = S_IDLE;
          cnt_clear = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // state and registered status flags
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      o_running   <= 1'b0;
      o_halted    <= 1'b0;
      o_step_done <= 1'b0;
    end else begin
      state       <= state_n;
      o_running   <= (state_n == S_RUN);
      o_halted    <= (state_n == S_HALTED);
      o_step_done <= (state == S_STEP);
    end
  end

  sat_counter #(
    .N_BITS (N_BITS)
  ) u_cnt (
    .clk   (i_clk),
    .reset (i_reset),
    .clear (cnt_clear),
    .load1 (cnt_load1),
    .inc   (o_enable),
    .count (o_cycle_count)
  );

endmodule

// File: tb/tb_exec_step_ctrl.sv
// Directed bench for exec_step_ctrl.
// Second instance with N_BITS=4 covers saturation.
module tb_exec_step_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic        halt;
  logic        enable;
  logic        running;
  logic        halted;
  logic        step_done;
  logic [31:0] count;

  logic        cmd_valid4;
  logic [1:0]  cmd4;
  logic        cmd_ready4;
  logic        halt4;
  logic        enable4;
  logic        running4;
  logic        halted4;
  logic        step_done4;
  logic [3:0]  count4;

  int errs;
  int checks;

  localparam logic [1:0] CLR = 2'b00;
  localparam logic [1:0] RUN = 2'b01;
  localparam logic [1:0] STP = 2'b10;
  localparam logic [1:0] PAU = 2'b11;

  exec_step_ctrl #(.N_BITS(32), .N_CMD(2)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .i_cmd         (cmd),
    .o_cmd_ready   (cmd_ready),
    .i_halt_wb     (halt),
    .o_enable      (enable),
    .o_running     (running),
    .o_halted      (halted),
    .o_step_done   (step_done),
    .o_cycle_count (count)
  );

  exec_step_ctrl #(.N_BITS(4), .N_CMD(2)) dut4 (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_cmd_valid   (cmd_valid4),
    .i_cmd         (cmd4),
    .o_cmd_ready   (cmd_ready4),
    .i_halt_wb     (halt4),
    .o_enable      (enable4),
    .o_running     (running4),
    .o_halted      (halted4),
    .o_step_done   (step_done4),
    .o_cycle_count (count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    checks++;
    if (enable !== 1'b0 || running !== 1'b0 || halted !== 1'b0 ||
        step_done !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_flags en=%b run=%b hlt=%b sd=%b rdy=%b want 0 0 0 0 1",
               enable, running, halted, step_done, cmd_ready);
    end
    checks++;
    if (count !== 32'd0) begin
      errs++;
      $display("FAIL reset_count got=%0d want=0", count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (enable !== 1'b0 || count !== 32'd0) begin
      errs++;
      $display("FAIL post_reset_idle en=%b cnt=%0d want 0 0", enable, count);
    end
  endtask

  task automatic test_step();
    send(STP);
    checks++;
    if (enable !== 1'b1 || cmd_ready !== 1'b0 || step_done !== 1'b0) begin
      errs++;
      $display("FAIL step_active en=%b rdy=%b sd=%b want 1 0 0",
               enable, cmd_ready, step_done);
    end
    tick();
    checks++;
    if (enable !== 1'b0 || step_done !== 1'b1 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL step_done en=%b sd=%b rdy=%b want 0 1 1",
               enable, step_done, cmd_ready);
    end
    checks++;
    if (count !== 32'd1) begin
      errs++;
      $display("FAIL step_count got=%0d want=1", count);
    end
    tick();
    checks++;
    if (step_done !== 1'b0 || halted !== 1'b0 || running !== 1'b0) begin
      errs++;
      $display("FAIL step_pulse_end sd=%b hlt=%b run=%b want 0 0 0",
               step_done, halted, running);
    end
  endtask

  task automatic test_run_pause();
    send(CLR);
    checks++;
    if (count !== 32'd0) begin
      errs++;
      $display("FAIL idle_clear got=%0d want=0", count);
    end
    send(RUN);
    checks++;
    if (enable !== 1'b1 || running !== 1'b1 || count !== 32'd0) begin
      errs++;
      $display("FAIL run_start en=%b run=%b cnt=%0d want 1 1 0",
               enable, running, count);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (count !== 32'd9 || enable !== 1'b1) begin
      errs++;
      $display("FAIL run_mid cnt=%0d en=%b want 9 1", count, enable);
    end
    send(PAU);
    checks++;
    if (count !== 32'd10 || enable !== 1'b0 || running !== 1'b0) begin
      errs++;
      $display("FAIL run_pause cnt=%0d en=%b run=%b want 10 0 0",
               count, enable, running);
    end
    tick();
    checks++;
    if (count !== 32'd10) begin
      errs++;
      $display("FAIL pause_hold got=%0d want=10", count);
    end
  endtask

  task automatic test_run_clear();
    send(RUN);
    tick();
    tick();
    send(CLR);
    checks++;
    if (count !== 32'd1 || running !== 1'b1) begin
      errs++;
      $display("FAIL run_clear cnt=%0d run=%b want 1 1", count, running);
    end
    tick();
    checks++;
    if (count !== 32'd2) begin
      errs++;
      $display("FAIL run_clear_next got=%0d want=2", count);
    end
    send(PAU);
  endtask

  task automatic test_halt();
    send(CLR);
    send(RUN);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (count !== 32'd4) begin
      errs++;
      $display("FAIL halt_pre got=%0d want=4", count);
    end
    halt = 1'b1;
    send(PAU);
    halt = 1'b0;
    checks++;
    if (count !== 32'd5 || halted !== 1'b1 || enable !== 1'b0 ||
        running !== 1'b0) begin
      errs++;
      $display("FAIL halt_enter cnt=%0d hlt=%b en=%b run=%b want 5 1 0 0",
               count, halted, enable, running);
    end
    send(RUN);
    tick();
    checks++;
    if (halted !== 1'b1 || enable !== 1'b0 || count !== 32'd5) begin
      errs++;
      $display("FAIL halt_ignore hlt=%b en=%b cnt=%0d want 1 0 5",
               halted, enable, count);
    end
    send(CLR);
    checks++;
    if (halted !== 1'b0 || count !== 32'd0 || enable !== 1'b0) begin
      errs++;
      $display("FAIL halt_clear hlt=%b cnt=%0d en=%b want 0 0 0",
               halted, count, enable);
    end
  endtask

  task automatic test_step_halt();
    send(STP);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (halted !== 1'b1 || step_done !== 1'b1 || count !== 32'd1) begin
      errs++;
      $display("FAIL step_halt hlt=%b sd=%b cnt=%0d want 1 1 1",
               halted, step_done, count);
    end
    send(CLR);
    checks++;
    if (halted !== 1'b0 || count !== 32'd0 || step_done !== 1'b0) begin
      errs++;
      $display("FAIL step_halt_clr hlt=%b cnt=%0d sd=%b want 0 0 0",
               halted, count, step_done);
    end
  endtask

  task automatic test_async_reset();
    send(RUN);
    tick();
    tick();
    checks++;
    if (count !== 32'd2) begin
      errs++;
      $display("FAIL areset_pre got=%0d want=2", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (enable !== 1'b0 || count !== 32'd0 || running !== 1'b0) begin
      errs++;
      $display("FAIL areset_now en=%b cnt=%0d run=%b want 0 0 0",
               enable, count, running);
    end
    #3;
    rst_n = 1'b1;
    send(RUN);
    checks++;
    if (enable !== 1'b1 || count !== 32'd0) begin
      errs++;
      $display("FAIL areset_restart en=%b cnt=%0d want 1 0", enable, count);
    end
    tick();
    checks++;
    if (count !== 32'd1) begin
      errs++;
      $display("FAIL areset_count got=%0d want=1", count);
    end
    send(PAU);
    send(CLR);
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1;
    cmd = STP;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (cmd_ready !== 1'b0 || enable !== 1'b1 ||
          count !== 32'(k - 1)) begin
        errs++;
        $display("FAIL b2b_step%0d rdy=%b en=%b cnt=%0d want 0 1 %0d",
                 k, cmd_ready, enable, count, k - 1);
      end
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || enable !== 1'b0 || step_done !== 1'b1 ||
          count !== 32'(k)) begin
        errs++;
        $display("FAIL b2b_idle%0d rdy=%b en=%b sd=%b cnt=%0d want 1 0 1 %0d",
                 k, cmd_ready, enable, step_done, count, k);
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_saturate();
    cmd_valid4 = 1'b1;
    cmd4 = RUN;
    tick();
    cmd_valid4 = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (count4 !== 4'd15) begin
      errs++;
      $display("FAIL sat_reach got=%0d want=15", count4);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (count4 !== 4'd15 || enable4 !== 1'b1) begin
      errs++;
      $display("FAIL sat_hold cnt=%0d en=%b want 15 1", count4, enable4);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    cmd_valid = 1'b0;
    cmd = CLR;
    halt = 1'b0;
    cmd_valid4 = 1'b0;
    cmd4 = CLR;
    halt4 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_step();
    test_run_pause();
    test_run_clear();
    test_halt();
    test_step_halt();
    test_async_reset();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/exec_step_ctrl.md
EXEC_STEP_CTRL -- requirements
Module: exec_step_ctrl

Interface
REQ-001 SHALL have parameter N_BITS, default 32, width of the cycle counter.
REQ-002 SHALL have parameter N_CMD, default 2, width of the command code.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port i_cmd_valid  input  1  a command is presented on i_cmd.
REQ-006 SHALL have port i_cmd  input  N_CMD  command code: 00 CLEAR, 01 RUN, 10 STEP, 11 PAUSE.
REQ-007 SHALL have port o_cmd_ready  output  1  the controller accepts a command this cycle.
REQ-008 SHALL have port i_halt_wb  input  1  a halt instruction is in WB; sampled only while o_enable=1.
REQ-009 SHALL have port o_enable  output  1  global enable for all pipeline stages (IF..WB, execute included).
REQ-010 SHALL have port o_running  output  1  state is RUN.
REQ-011 SHALL have port o_halted  output  1  state is HALTED.
REQ-012 SHALL have port o_step_done  output  1  one-cycle pulse after a STEP cycle completes.
REQ-013 SHALL have port o_cycle_count  output  N_BITS  number of enabled pipeline cycles since the last CLEAR or reset.

Function
REQ-014 SHALL accept a command on a rising edge where i_cmd_valid=1 and o_cmd_ready=1; ignore i_cmd otherwise.
REQ-015 SHALL implement states IDLE, RUN, STEP, HALTED.
REQ-016 SHALL drive o_cmd_ready=1 in IDLE, RUN, HALTED; 0 in STEP.
REQ-017 SHALL drive o_enable as a Moore output: 1 in RUN and STEP, 0 in IDLE and HALTED.
REQ-018 IDLE: RUN -> RUN; STEP -> STEP; CLEAR -> stay IDLE with counter to 0; PAUSE -> stay IDLE.
REQ-019 RUN: i_halt_wb=1 -> HALTED; else PAUSE -> IDLE; else CLEAR -> RUN with counter set to 1 (current enabled cycle counted); RUN and STEP -> stay RUN.
REQ-020 STEP: after exactly one cycle, -> HALTED if i_halt_wb=1, else -> IDLE.
REQ-021 HALTED: CLEAR -> IDLE with counter to 0; RUN, STEP, PAUSE ignored; leaves only on CLEAR or reset.
REQ-022 i_halt_wb SHALL take priority over any simultaneously accepted command.
REQ-023 o_cycle_count SHALL increment by 1 on each rising edge where o_enable=1, including the cycle in which halt is sampled.
REQ-024 o_cycle_count SHALL saturate at all-ones; no wrap-around.
REQ-025 o_step_done SHALL be registered, high for exactly the one cycle after the STEP state, including when that step ends in HALTED.
REQ-026 Latency: o_enable SHALL rise in the cycle after RUN/STEP acceptance and fall in the cycle after PAUSE acceptance or halt detection.
REQ-027 Each STEP SHALL yield exactly one o_enable=1 cycle; back-to-back STEPs SHALL be separated by at least one IDLE cycle.

Reset
REQ-028 While i_reset=0, the block SHALL asynchronously force: state IDLE, o_enable=0, o_running=0, o_halted=0, o_step_done=0, o_cycle_count=0; o_cmd_ready=1.
REQ-029 Reset asserted mid-RUN or mid-STEP SHALL drop o_enable immediately, without completing the step or pulsing o_step_done.
REQ-030 Release of i_reset SHALL take effect on the first following rising edge of i_clk; no command is accepted before that edge.

Structure
REQ-031 State encoding and command codes (CLEAR/RUN/STEP/PAUSE) SHALL live in a shared package used by this block and the debug/UART front end.
REQ-032 The saturating counter SHALL be a separate sub-module, sat_counter (params N_BITS; ports clk, reset, clear, load1, inc, count).
REQ-033 FSM next-state logic SHALL be combinational; all outputs except o_cmd_ready and o_enable SHALL be registered.

Verification
REQ-034 Reset, then STEP -> o_enable high exactly 1 cycle, o_step_done pulse next cycle, count=1, state IDLE.
REQ-035 RUN, PAUSE accepted 10 cycles later -> 10 enabled cycles, count=10, o_running 1->0, o_enable low the following cycle.
REQ-036 RUN, i_halt_wb=1 on 5th enabled cycle with PAUSE in the same cycle -> HALTED, count=5, o_halted=1; subsequent RUN ignored; CLEAR -> IDLE, count=0.
REQ-037 N_BITS=4, RUN for 20 cycles -> count holds at 15.
REQ-038 i_reset=0 asynchronously mid-RUN (between edges) -> o_enable=0 and count=0 immediately; RUN after release restarts from count 0.
REQ-039 STEP held valid continuously -> o_cmd_ready toggles 1,0 and o_enable pulses every other cycle; count increments once per accepted STEP.
